// File: rtl/ssc_sort_ctrl_pkg.sv
// ssc_pkg: shared types and default widths for the sort-engine sequencer.
//   ssc_state_e : sequencer states
//   DATA_W_DEF  : default element width
//   ADDR_W_DEF  : default memory address width
package ssc_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        RDA,
        RDB,
        CMP,
        WR_A,
        WR_B
    } ssc_state_e;

endpackage

// File: rtl/ssc_sort_ctrl_if.sv
// ssc_sort_ctrl_if: Start/Done handshake plus the single-port memory bus.
//   master : the sequencer (drives Busy/Done/Mem_*/Swap_Count, takes Start/Mem_Rd_Data)
//   slave  : wrapper + memory side (drives Start and Mem_Rd_Data)
interface ssc_sort_ctrl_if
    import ssc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic                  Start;
    logic                  Busy;
    logic                  Done;
    logic [ADDR_W-1:0]     Mem_Addr;
    logic                  Mem_Wr_En;
    logic [DATA_W-1:0]     Mem_Wr_Data;
    logic [DATA_W-1:0]     Mem_Rd_Data;
    logic [2*ADDR_W-1:0]   Swap_Count;

    modport master (
        input  Start, Mem_Rd_Data,
        output Busy, Done, Mem_Addr, Mem_Wr_En, Mem_Wr_Data, Swap_Count
    );

    modport slave (
        output Start, Mem_Rd_Data,
        input  Busy, Done, Mem_Addr, Mem_Wr_En, Mem_Wr_Data, Swap_Count
    );
endinterface

// File: rtl/ssc_sort_ctrl_cmp_swap.sv
// ssc_cmp_swap: combinational swap decision for one adjacent pair.
//   a       : element at the lower address
//   rd      : element at the higher address
//   do_swap : pair is out of order; equal values never swap
module ssc_cmp_swap #(
    parameter int DATA_W     = 16,
    parameter int DESCENDING = 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] rd,
    output logic              do_swap
);
    assign do_swap = (DESCENDING != 0) ? (a < rd) : (a > rd);
endmodule

// File: rtl/ssc_sort_ctrl.sv
// ssc_sort_ctrl: in-place bubble-sort sequencer for a single-port, sync-read memory.
//   Clk, Rst : clock and synchronous active-high reset
//   bus      : Start/Busy/Done handshake, memory address/write port, read data,
//              and the saturating swap counter of the current/last sort
// Each pair costs RDA, RDB, CMP (+ WR_A, WR_B on a swap). The pass bound hi
// shrinks after every pass; a pass without swaps ends the sort early.
module ssc_sort_ctrl
    import ssc_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DEPTH      = 256,
    parameter int DESCENDING = 1
) (
    input  logic            Clk,
    input  logic            Rst,
    ssc_sort_ctrl_if.master bus
);
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] HI_INIT = ADDR_W'(DEPTH - 1);

    ssc_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     i_q, i_d;
    logic [ADDR_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     a_q, a_d;
    logic [DATA_W-1:0]     b_q, b_d;
    logic                  swapped_q, swapped_d;
    logic                  done_q, done_d;
    logic [2*ADDR_W-1:0]   swc_q, swc_d;

    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_we;
    logic [DATA_W-1:0]     mem_wd;
    logic                  do_swap;
    logic                  pass_end;
    logic                  any_swap;

    ssc_cmp_swap #(
        .DATA_W     (DATA_W),
        .DESCENDING (DESCENDING)
    ) u_cmp (
        .a       (a_q),
        .rd      (bus.Mem_Rd_Data),
        .do_swap (do_swap)
    );

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        hi_d      = hi_q;
        a_d       = a_q;
        b_d       = b_q;
        swapped_d = swapped_q;
        done_d    = done_q;
        swc_d     = swc_q;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wd    = '0;
        pass_end  = 1'b0;
        any_swap  = swapped_q;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d   = RDA;
                    i_d       = '0;
                    hi_d      = HI_INIT;
                    swapped_d = 1'b0;
                    done_d    = 1'b0;
                    swc_d     = '0;
                end
            end
            RDA: begin
                mem_addr = i_q;
                state_d  = RDB;
            end
            RDB: begin
                // read data now holds mem[i]; mem[i+1] is requested
                mem_addr = i_q + ONE;
                a_d      = bus.Mem_Rd_Data;
                state_d  = CMP;
            end
            CMP: begin
                if (do_swap) begin
                    b_d     = bus.Mem_Rd_Data;
                    state_d = WR_A;
                end else begin
                    pass_end = 1'b1;
                end
            end
            WR_A: begin
                mem_addr = i_q;
                mem_we   = 1'b1;
                mem_wd   = b_q;
                state_d  = WR_B;
            end
            WR_B: begin
                mem_addr  = i_q + ONE;
                mem_we    = 1'b1;
                mem_wd    = a_q;
                swapped_d = 1'b1;
                any_swap  = 1'b1;
                if (swc_q != '1) swc_d = swc_q + 1'b1;
                pass_end  = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // any_swap folds in the swap completing this cycle, which swapped_q
        // does not show yet
        if (pass_end) begin
            if (i_q < hi_q - ONE) begin
                i_d     = i_q + ONE;
                state_d = RDA;
            end else if (any_swap && (hi_q > ONE)) begin
                hi_d      = hi_q - ONE;
                i_d       = '0;
                swapped_d = 1'b0;
                state_d   = RDA;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            i_q       <= '0;
            hi_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            swapped_q <= 1'b0;
            done_q    <= 1'b0;
            swc_q     <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            hi_q      <= hi_d;
            a_q       <= a_d;
            b_q       <= b_d;
            swapped_q <= swapped_d;
            done_q    <= done_d;
            swc_q     <= swc_d;
        end
    end

    assign bus.Busy        = (state_q != IDLE);
    assign bus.Done        = done_q;
    assign bus.Mem_Addr    = mem_addr;
    assign bus.Mem_Wr_En   = mem_we;
    assign bus.Mem_Wr_Data = mem_wd;
    assign bus.Swap_Count  = swc_q;
endmodule

// File: tb/tb_ssc_sort_ctrl.sv
// Bench for ssc_sort_ctrl: four sequencers (256/desc, 64/desc, 2/desc, 2/asc)
// share one 256-entry sync-read memory, only the selected one being active.
// Expected results come from a histogram rebuild of the loaded values and a
// pairwise inversion count.
module tb_ssc_sort_ctrl;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int DEP [4] = '{256, 64, 2, 2};
    localparam int DSC [4] = '{1, 1, 1, 0};

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    logic [3:0]    start = '0;
    logic [3:0]    busy, done, we;
    logic [AW-1:0] addr [4];
    logic [DW-1:0] wd   [4];
    logic [2*AW-1:0] swc [4];
    logic [DW-1:0] rd;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ssc_sort_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
        ssc_sort_ctrl #(
            .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP[g]), .DESCENDING(DSC[g])
        ) u_dut (
            .Clk (Clk),
            .Rst (Rst),
            .bus (bus)
        );
        assign bus.Start       = start[g];
        assign bus.Mem_Rd_Data = rd;
        assign busy[g] = bus.Busy;
        assign done[g] = bus.Done;
        assign we[g]   = bus.Mem_Wr_En;
        assign addr[g] = bus.Mem_Addr;
        assign wd[g]   = bus.Mem_Wr_Data;
        assign swc[g]  = bus.Swap_Count;
    end

    // shared memory with a bench load port
    logic [DW-1:0] mem [256];
    int            sel = 0;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    int            wr_pulses = 0;

    always @(posedge Clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (we[sel]) mem[addr[sel]] <= wd[sel];
        rd <= mem[addr[sel]];
        if (we[sel]) wr_pulses <= wr_pulses + 1;
    end

    int checks = 0;
    int failures = 0;
    int v [256];           // ordering keys of the loaded data
    logic [DW-1:0] img [256];

    function automatic logic [DW-1:0] enc(int k);
        return DW'(k * 257);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(int d, bit raw);
        sel = d;
        for (int k = 0; k < DEP[d]; k++) begin
            if (!raw) img[k] = enc(v[k]);
            ld_en   = 1'b1;
            ld_addr = AW'(k);
            ld_data = img[k];
            @(posedge Clk); #1;
        end
        ld_en = 1'b0;
    endtask

    task automatic kick(int d);
        @(negedge Clk); start[d] = 1'b1;
        @(posedge Clk); #1; start[d] = 1'b0;
        chk("accept_busy", 32'(busy[d]), 1);
        chk("accept_done_clr", 32'(done[d]), 0);
    endtask

    task automatic wait_done(int d, int maxc, inout int cyc);
        while (!done[d] && cyc < maxc) begin
            @(posedge Clk); #1; cyc++;
        end
        chk("done_in_budget", 32'(done[d]), 1);
        chk("busy_clr_at_done", 32'(busy[d]), 0);
    endtask

    function automatic int inversions(int d);
        int cnt = 0;
        for (int j = 0; j < DEP[d]; j++)
            for (int k = j + 1; k < DEP[d]; k++)
                if (DSC[d] != 0 ? v[j] < v[k] : v[j] > v[k]) cnt++;
        return cnt;
    endfunction

    // rebuild the sorted image from a histogram of the keys
    task automatic check_sorted(int d, string tag);
        int hist [256];
        int idx = 0;
        logic [DW-1:0] exp [256];
        for (int b = 0; b < 256; b++) hist[b] = 0;
        for (int k = 0; k < DEP[d]; k++) hist[v[k]]++;
        for (int b = 0; b < 256; b++) begin
            int key = (DSC[d] != 0) ? 255 - b : b;
            for (int r = 0; r < hist[key]; r++) begin
                exp[idx] = enc(key);
                idx++;
            end
        end
        for (int k = 0; k < DEP[d]; k++) chk(tag, 32'(mem[k]), 32'(exp[k]));
    endtask

    initial begin
        int cyc;
        int base;
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;

        // reset state of every instance
        repeat (3) @(posedge Clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk("rst_busy", 32'(busy[d]), 0);
            chk("rst_done", 32'(done[d]), 0);
            chk("rst_we", 32'(we[d]), 0);
            chk("rst_swc", 32'(swc[d]), 0);
            chk("rst_addr", 32'(addr[d]), 0);
            chk("rst_wd", 32'(wd[d]), 0);
        end
        @(negedge Clk); Rst = 1'b0;

        // already descending 255..0: single pass of 255 three-cycle compares
        for (int k = 0; k < 256; k++) v[k] = 255 - k;
        load(0, 1'b0);
        cyc = 0; kick(0); wait_done(0, 2000, cyc);
        chk("sorted_cycles", 32'(cyc), 765);
        chk("sorted_swc", 32'(swc[0]), 0);
        check_sorted(0, "sorted_mem");

        // restart from Done=1 on the same data
        cyc = 0; kick(0); wait_done(0, 2000, cyc);
        chk("restart_cycles", 32'(cyc), 765);
        chk("restart_swc", 32'(swc[0]), 0);

        // all-equal data: no swaps, no write strobes
        for (int k = 0; k < 256; k++) img[k] = 16'h1234;
        load(0, 1'b1);
        base = wr_pulses;
        cyc = 0; kick(0); wait_done(0, 2000, cyc);
        chk("const_cycles", 32'(cyc), 765);
        chk("const_swc", 32'(swc[0]), 0);
        chk("const_no_writes", 32'(wr_pulses - base), 0);
        for (int k = 0; k < 256; k++) chk("const_mem", 32'(mem[k]), 32'h1234);

        // reset 100 cycles into a sort
        for (int k = 0; k < 256; k++) v[k] = k;
        load(0, 1'b0);
        kick(0);
        repeat (99) @(posedge Clk);
        #1;
        chk("pre_abort_busy", 32'(busy[0]), 1);
        @(negedge Clk); Rst = 1'b1;
        @(posedge Clk); #1;
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_done", 32'(done[0]), 0);
        chk("abort_we", 32'(we[0]), 0);
        @(negedge Clk); Rst = 1'b0;

        // ascending 0..63 on the 64-deep instance: fully reversed
        for (int k = 0; k < 64; k++) v[k] = k;
        load(1, 1'b0);
        cyc = 0; kick(1); wait_done(1, 20000, cyc);
        chk("asc_swc", 32'(swc[1]), 32'(inversions(1)));
        chk("asc_swc_const", 32'(swc[1]), 2016);
        chk("asc_cycles", 32'(cyc), 32'(2016 * 5));
        check_sorted(1, "asc_mem");

        // random data with duplicates, with a Start pulse while Busy
        for (int t = 0; t < 2; t++) begin
            for (int k = 0; k < 64; k++)
                v[k] = (t == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255));
            load(1, 1'b0);
            cyc = 0; kick(1);
            repeat (40) begin @(posedge Clk); #1; cyc++; end
            @(negedge Clk); start[1] = 1'b1;
            @(posedge Clk); #1; start[1] = 1'b0; cyc++;
            chk("busy_start_ignored", 32'(busy[1]), 1);
            wait_done(1, 20000, cyc);
            chk("rand_swc", 32'(swc[1]), 32'(inversions(1)));
            check_sorted(1, "rand_mem");
        end

        // two-entry instances
        v[0] = 1; v[1] = 9;
        load(2, 1'b0);
        cyc = 0; kick(2); wait_done(2, 100, cyc);
        chk("d2_desc_cycles", 32'(cyc), 5);
        chk("d2_desc_swc", 32'(swc[2]), 1);
        check_sorted(2, "d2_desc_mem");

        load(3, 1'b0);
        cyc = 0; kick(3); wait_done(3, 100, cyc);
        chk("d2_asc_cycles", 32'(cyc), 3);
        chk("d2_asc_swc", 32'(swc[3]), 0);
        check_sorted(3, "d2_asc_mem");

        v[0] = 9; v[1] = 1;
        load(3, 1'b0);
        cyc = 0; kick(3); wait_done(3, 100, cyc);
        chk("d2_asc_swap_cycles", 32'(cyc), 5);
        chk("d2_asc_swap_swc", 32'(swc[3]), 1);
        check_sorted(3, "d2_asc_swap_mem");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
